// File: rtl/sram_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sram_controller
//  Description : MEM-stage memory port. Splits one 32-bit load/store into two
//                16-bit accesses on an external asynchronous SRAM and holds
//                ready low while the access is in flight, which freezes the
//                pipeline.
//  Ports       : clk, rst_n            clock, async active-low reset
//                wr_en, rd_en          store / load request (write wins)
//                address, write_data   byte address and store data
//                read_data             registered load result
//                ready                 0 = freeze pipeline
//                SRAM_*                external SRAM pins (UB/LB/CE/OE tied 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int c_idx_w = SRAM_ADDR_W - 1;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_lo   = 3'd1;
    localparam logic [2:0] c_st_hi   = 3'd2;
    localparam logic [2:0] c_st_wait = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

    localparam logic [3:0]         c_wait_last = 4'(WAIT_CYCLES);
    localparam logic [c_idx_w-1:0] c_base_idx  = BASE_ADDR[SRAM_ADDR_W:2];

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [c_idx_w-1:0] r_idx;
    logic [31:0]        r_wdata;
    logic               r_is_write;
    logic [15:0]        r_lo;
    logic [15:0]        r_hi;
    logic [3:0]         r_wait_cnt;

    logic               w_req;
    logic [c_idx_w-1:0] w_idx;
    logic               w_dq_drive;
    logic [15:0]        w_dq_out;
    logic [15:0]        w_hi_half;
    logic               w_unused_addr_bits;

    assign w_req = wr_en | rd_en;

    // Subtracting on the word-index bits only keeps address[1:0] out of the
    // result; the wrap below BASE_ADDR falls out of the truncation.
    assign w_idx = address[SRAM_ADDR_W:2] - c_base_idx;
    assign w_unused_addr_bits = ^{address[31:SRAM_ADDR_W+1], address[1:0]};

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (w_req) w_next = c_st_lo;
            c_st_lo:   w_next = c_st_hi;
            c_st_hi:   w_next = (WAIT_CYCLES > 0) ? c_st_wait : c_st_done;
            c_st_wait: if (r_wait_cnt == c_wait_last) w_next = c_st_done;
            c_st_done: w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from the state register so an async reset releases
    // the bus in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        ready      = (r_state == c_st_done) | ((r_state == c_st_idle) & ~w_req);
        SRAM_ADDR  = '0;
        w_dq_drive = 1'b0;
        w_dq_out   = r_wdata[15:0];
        case (r_state)
            c_st_lo: begin
                SRAM_ADDR  = {r_idx, 1'b0};
                w_dq_drive = r_is_write;
            end
            c_st_hi: begin
                SRAM_ADDR  = {r_idx, 1'b1};
                w_dq_drive = r_is_write;
                w_dq_out   = r_wdata[31:16];
            end
            default: ;
        endcase
    end

    assign SRAM_WE_N = ~w_dq_drive;
    assign SRAM_DQ   = w_dq_drive ? w_dq_out : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    // With no settle cycles the high half arrives straight from the bus on
    // the HI->DONE edge; otherwise it was parked in r_hi.
    assign w_hi_half = (r_state == c_st_hi) ? SRAM_DQ : r_hi;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_wait_cnt <= '0;
            read_data  <= '0;
        end else begin
            r_state <= w_next;

            if ((r_state == c_st_idle) && w_req) begin
                r_idx      <= w_idx;
                r_wdata    <= write_data;
                r_is_write <= wr_en;
            end

            if ((r_state == c_st_lo) && !r_is_write) r_lo <= SRAM_DQ;
            if ((r_state == c_st_hi) && !r_is_write) r_hi <= SRAM_DQ;

            if (r_state == c_st_hi) begin
                r_wait_cnt <= 4'd1;
            end else if (r_state == c_st_wait) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end

            // DONE is only entered from HI or WAIT, so this fires once per load.
            if ((w_next == c_st_done) && !r_is_write) begin
                read_data <= {w_hi_half, r_lo};
            end
        end
    end

endmodule
`default_nettype wire
